// File: rtl/audio_pkg.sv
// audio_pkg: shared constants, sample type, read FSM encoding and the
// Q0.16 window rounding helper for the audio_framer slice.
package audio_pkg;

  localparam int ADC_MID  = 2048;
  localparam int ADC_W    = 12;
  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    STREAM   = 2'd2
  } rd_state_e;

  // Round a Q1.15 x Q0.16 product back to Q1.15 with saturation.
  function automatic sample_t win_round(input logic signed [32:0] prod);
    logic signed [33:0] r;
    r = 34'(prod) + 34'sd32768;
    r = r >>> 16;
    if (r > 34'sd32767) begin
      return 16'sh7FFF;
    end else if (r < -34'sd32768) begin
      return 16'sh8000;
    end else begin
      return r[15:0];
    end
  endfunction

endpackage

// File: rtl/audio_framer_bank_ram.sv
// framer_bank_ram: ping-pong sample store addressed as {bank, index};
// one write port and one registered read port with read enable.
module framer_bank_ram
  import audio_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  sample_t       wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output sample_t       rd_data_o
);

  sample_t mem_q [DEPTH];
  sample_t rd_data_q;

  // Sample storage write; left without reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read that only advances on request, so data holds during stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/audio_framer_hann_rom.sv
// hann_rom: Hann window coefficients, unsigned Q0.16, one per frame index.
// Only built when AUDIO_FRAMER_WINDOW_EN is defined.
`ifdef AUDIO_FRAMER_WINDOW_EN
module hann_rom #(
  parameter int FRAME_LEN = 256,
  parameter int IDX_W     = 8
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [15:0]      coef_o
);

  logic [15:0] rom_s [FRAME_LEN];

  for (genvar g = 0; g < FRAME_LEN; g++) begin : g_rom
    localparam real PI_R = 3.14159265358979;
    localparam real W_R  = 0.5 * (1.0 - $cos(2.0 * PI_R * g / FRAME_LEN));
    localparam int  C_RAW = int'(W_R * 65536.0);
    // The centre tap is 1.0, which only fits as 0xFFFF
    localparam int  C_SAT = (C_RAW > 65535) ? 65535 : C_RAW;
    assign rom_s[g] = 16'(C_SAT);
  end

  assign coef_o = rom_s[idx_i];

endmodule
`endif

// File: rtl/audio_framer.sv
// audio_framer: ADC DC removal, block-average decimation, ping-pong framing
// and valid/ready frame streaming with start/end markers.
// Define AUDIO_FRAMER_WINDOW_EN to apply a Hann window on the output path
// (adds one stall-aware pipeline register).
module audio_framer
  import audio_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int DECIM     = 4,
  parameter int OUT_W     = 16,
  localparam int IDX_W    = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADC_W-1:0] in_data,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_eof,
  output logic [IDX_W-1:0] out_index,
  output logic             overrun,
  output logic [15:0]      frame_count
);

  localparam int LOG2D = $clog2(DECIM);
  localparam int ACC_W = ADC_W + LOG2D + 1;
  localparam int CNT_W = (LOG2D > 0) ? LOG2D : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DECIM - 1);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        dcnt_q, dcnt_d;
  logic                    wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
  logic [1:0]              full_q, full_d;
  logic                    overrun_q, overrun_d;
  rd_state_e               state_q, state_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
  logic [15:0]             fc_q, fc_d;

  logic signed [ADC_W:0]   s_s;
  logic signed [ACC_W-1:0] sum_s, avg_s;
  sample_t                 smp_s, rd_data_s;
  logic                    ram_we_s, set_full_s, clr_full_s, bank_busy_s;
  logic                    rd_en_s, core_valid_s, core_ready_s, core_acc_s;
  logic [IDX_W-1:0]        rd_addr_idx_s;

  // DC removal, running sum and the averaged sample scaled to Q1.15
  assign s_s   = {1'b0, in_data} - (ADC_W + 1)'(ADC_MID);
  assign sum_s = acc_q + ACC_W'(s_s);
  assign avg_s = sum_s >>> LOG2D;
  assign smp_s = sample_t'(avg_s) <<< 4;

  // A bank the reader is releasing this cycle already counts as free
  assign bank_busy_s  = full_q[wr_bank_q] && !(clr_full_s && (rd_bank_q == wr_bank_q));
  assign core_valid_s = (state_q == STREAM);
  assign core_acc_s   = core_valid_s && core_ready_s;

  // Decimation counter and bank write / drop decision
  always_comb begin
    acc_d      = acc_q;
    dcnt_d     = dcnt_q;
    wr_bank_d  = wr_bank_q;
    wr_idx_d   = wr_idx_q;
    overrun_d  = overrun_q;
    ram_we_s   = 1'b0;
    set_full_s = 1'b0;
    if (in_valid) begin
      if (dcnt_q == LAST_CNT) begin
        acc_d  = '0;
        dcnt_d = '0;
        if (bank_busy_s) begin
          overrun_d = 1'b1;
        end else begin
          ram_we_s = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            set_full_s = 1'b1;
            wr_bank_d  = ~wr_bank_q;
            wr_idx_d   = '0;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end else begin
        acc_d  = sum_s;
        dcnt_d = dcnt_q + CNT_W'(1);
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Read FSM: wait for a full bank, prefetch index 0, then stream with lookahead
  always_comb begin
    state_d       = state_q;
    rd_bank_d     = rd_bank_q;
    rd_idx_d      = rd_idx_q;
    rd_en_s       = 1'b0;
    rd_addr_idx_s = rd_idx_q;
    clr_full_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = PREFETCH;
        end else begin
          state_d = IDLE;
        end
      end
      PREFETCH: begin
        rd_en_s       = 1'b1;
        rd_addr_idx_s = '0;
        rd_idx_d      = '0;
        state_d       = STREAM;
      end
      STREAM: begin
        if (core_acc_s) begin
          if (rd_idx_q == LAST_IDX) begin
            clr_full_s = 1'b1;
            rd_bank_d  = ~rd_bank_q;
            rd_idx_d   = '0;
            state_d    = IDLE;
          end else begin
            rd_en_s       = 1'b1;
            rd_addr_idx_s = rd_idx_q + IDX_W'(1);
            rd_idx_d      = rd_idx_q + IDX_W'(1);
          end
        end else begin
          state_d = STREAM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bank-full flags (release before claim) and the streamed-frame counter
  always_comb begin
    full_d = full_q;
    if (clr_full_s) begin
      full_d[rd_bank_q] = 1'b0;
    end else begin
      full_d = full_q;
    end
    if (set_full_s) begin
      full_d[wr_bank_q] = 1'b1;
    end else begin
      full_d = full_d;
    end
    if (out_valid && out_ready && out_eof) begin
      fc_d = fc_q + 16'd1;
    end else begin
      fc_d = fc_q;
    end
  end

  // State register for write side, read FSM and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      dcnt_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      full_q    <= 2'b00;
      overrun_q <= 1'b0;
      state_q   <= IDLE;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      fc_q      <= 16'd0;
    end else begin
      acc_q     <= acc_d;
      dcnt_q    <= dcnt_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
      fc_q      <= fc_d;
    end
  end

  framer_bank_ram #(
    .DEPTH (2 * FRAME_LEN),
    .AW    (IDX_W + 1)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (ram_we_s),
    .wr_addr_i ({wr_bank_q, wr_idx_q}),
    .wr_data_i (smp_s),
    .rd_en_i   (rd_en_s),
    .rd_addr_i ({rd_bank_q, rd_addr_idx_s}),
    .rd_data_o (rd_data_s)
  );

`ifdef AUDIO_FRAMER_WINDOW_EN
  logic [15:0]        coef_s;
  logic signed [32:0] prod_s;
  logic               ov_q;
  sample_t            od_q;
  logic [IDX_W-1:0]   oidx_q;

  hann_rom #(
    .FRAME_LEN (FRAME_LEN),
    .IDX_W     (IDX_W)
  ) u_rom (
    .idx_i  (rd_idx_q),
    .coef_o (coef_s)
  );

  assign prod_s       = 33'(rd_data_s) * 33'($signed({1'b0, coef_s}));
  assign core_ready_s = !ov_q || out_ready;

  // Output pipeline register holding the windowed sample; stalls with out_ready
  always_ff @(posedge clk) begin
    if (reset) begin
      ov_q   <= 1'b0;
      od_q   <= '0;
      oidx_q <= '0;
    end else if (core_ready_s) begin
      ov_q <= core_valid_s;
      if (core_valid_s) begin
        od_q   <= win_round(prod_s);
        oidx_q <= rd_idx_q;
      end
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_index = oidx_q;
`else
  assign core_ready_s = out_ready;
  assign out_valid    = core_valid_s;
  assign out_data     = rd_data_s;
  assign out_index    = rd_idx_q;
`endif

  assign out_sof     = out_valid && (out_index == '0);
  assign out_eof     = out_valid && (out_index == LAST_IDX);
  assign overrun     = overrun_q;
  assign frame_count = fc_q;

endmodule

// File: doc/audio_framer.md
Name: audio_framer

Overview:
- Consumes the 12-bit unsigned ADC sample stream and removes DC (subtract 2048).
- Decimates by averaging DECIM samples, then packs results into FRAME_LEN-sample frames in a ping-pong buffer.
- Streams completed frames to the downstream FFT stage over valid/ready with start/end-of-frame markers.
- Sits directly downstream of the ADC sampling block; single clock domain.

Parameters:
- FRAME_LEN, 256, samples per output frame; power of 2, 16..1024.
- DECIM, 4, input samples averaged per stored sample; power of 2, 1..16.
- OUT_W, 16, output sample width; fixed at 16 in this revision.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  12  unsigned ADC code, 0..4095.
- in_valid  in  1  single-cycle strobe; one new sample per high cycle.
- out_data  out  16  signed Q1.15 sample.
- out_valid  out  1  out_data/out_sof/out_eof/out_index are valid.
- out_ready  in  1  downstream accepts on out_valid && out_ready.
- out_sof  out  1  high with index 0 of a frame.
- out_eof  out  1  high with index FRAME_LEN-1.
- out_index  out  log2(FRAME_LEN)  sample position in frame.
- overrun  out  1  sticky; set when a decimated sample is dropped; cleared only by reset.
- frame_count  out  16  completed frames fully streamed out; wraps at 65535->0.

Behaviour:
- Reset: all outputs 0; accumulator 0; decimation count 0; write bank 0, write index 0; both bank-full flags 0; read state IDLE.
- Conversion: s = {1'b0,in_data} - 2048, giving a 13-bit signed value in -2048..2047.
- Decimation: acc (12+log2(DECIM)+1 bits, signed) sums s over DECIM strobes.
  - avg = acc >>> log2(DECIM), arithmetic shift, truncation toward -inf.
  - Stored sample = avg << 4, 16-bit signed, so 2047 -> 0x7FF0 and -2048 -> 0x8000.
  - DECIM=1 passes s directly.
- Write side: on the cycle the DECIM-th strobe arrives, the stored sample is written to bank wr_bank at wr_idx; wr_idx increments.
  - At wr_idx = FRAME_LEN-1: set full[wr_bank], toggle wr_bank, wr_idx -> 0.
- Overrun: if full[wr_bank] is set when a decimated sample is due, the sample is dropped.
  - wr_idx is held, overrun is set, and the accumulator still restarts.
  - Writing resumes as soon as the bank is freed; that frame then contains only post-drop samples.
- Read FSM:
  - IDLE -> PREFETCH when full[rd_bank].
  - PREFETCH issues the registered RAM read of index 0, then -> STREAM.
  - STREAM holds out_valid=1. Outputs remain stable while out_ready=0. On accept, the next index is prefetched with no bubble, giving 1 sample/cycle with out_ready held high.
  - On accept of index FRAME_LEN-1: clear full[rd_bank], toggle rd_bank, increment frame_count, -> IDLE.
- Latency: bank becoming full -> out_valid high = 2 cycles (3 with window).
- Simultaneous events: a bank-clear by the reader and a write-side check in the same cycle see the bank as free (the clear takes priority).
- Mid-operation reset: discards the partial frame, buffered frames and any in-flight output. out_valid drops in the cycle after reset is sampled.
- in_valid while reset is high is ignored.

Optional Feature:
- Macro: AUDIO_FRAMER_WINDOW_EN.
- Defined:
  - Each output sample is multiplied by a Hann coefficient w[index] (unsigned Q0.16, ROM of FRAME_LEN entries).
  - out = (x*w + 2^15) >>> 16, saturated to 16-bit signed.
  - Adds one pipeline register; the handshake is unchanged (the register stalls with out_ready).
- Undefined: samples pass unwindowed; no ROM or multiplier is instantiated.

Decomposition:
- Package audio_pkg holds:
  - ADC_MID = 2048, ADC_W = 12, SAMPLE_W = 16;
  - typedef sample_t (signed 16);
  - read FSM enum {IDLE, PREFETCH, STREAM}.
- Sub-module framer_bank_ram: dual-port RAM, 2*FRAME_LEN x 16, one write port, one registered read port; address = {bank, index}.
- Window ROM hann_rom exists only under the macro.

Test Plan:
- DECIM=4, FRAME_LEN=16, in_data=4095 constant, strobe every 3 cycles, out_ready=1 -> one frame of 16 x 0x7FF0; sof on index 0, eof on index 15; frame_count=1; overrun=0.
- Ramp in_data 2048,2052,2056,2060 repeating (DECIM=4) -> every stored sample = avg 6 -> out_data 0x0060.
- out_ready toggled 1/0 every cycle, continuous input -> every output held stable while stalled; 16 distinct accepted indices 0..15 per frame, none duplicated.
- out_ready=0 for 3 frame-times with continuous input -> two frames buffered, overrun=1; on releasing out_ready, exactly 2 complete frames are emitted first.
- Assert reset for 1 cycle mid-STREAM at index 7 -> next cycle out_valid=0, frame_count=0, overrun=0; next frame starts at index 0.
- AUDIO_FRAMER_WINDOW_EN, in_data=4095 -> out index 0 = 0x0000, index FRAME_LEN/2 = 0x7FF0 (w=0xFFFF, rounded), symmetric about the centre.
